phase_scheduler: RTL and testbench
==================================

// Module: phase_scheduler
// PURPOSE
//   Demand-driven signal-phase controller for a two-road intersection. Sequences
//   G1 -> Y1 -> AR1 -> G2 -> Y2 -> AR2 -> G1. Green time scales with the queue
//   reported by each road's car counter, saturates at a maximum, and ends early
//   (gap-out) when the road empties while the other road waits. Sits between the
//   1 Hz tick generator / car counters and the lamp LEDs and time displays.
// PARAMETERS
//   CW        8   width of queue count inputs
//   TW        8   width of time counters and t_rem (all durations < 2**TW)
//   MIN_GREEN 5   minimum green, ticks (>=1)
//   MAX_GREEN 30  maximum computed green, ticks (>=MIN_GREEN)
//   PER_CAR   2   extra green ticks per queued car
//   YELLOW    3   yellow duration, ticks (>=1)
//   ALL_RED   1   all-red clearance duration, ticks (>=1)
// PORTS
//   clk      in   1   system clock
//   rst_n    in   1   asynchronous reset, active low
//   tick     in   1   1 Hz enable, one clk wide; each high cycle counts as one tick
//   q1       in   CW  cars queued on road 1
//   q2       in   CW  cars queued on road 2
//   g1,y1,r1 out  1   road 1 lamps (exactly one high)
//   g2,y2,r2 out  1   road 2 lamps (exactly one high)
//   t_rem    out  TW  ticks left in current phase; 0 while resting in green
//   phase    out  3   G1=0 Y1=1 AR1=2 G2=3 Y2=4 AR2=5 (6,7 unused -> AR2)
//   phase_end out 1   one-cycle pulse on every phase transition
// BEHAVIOUR
//   - All outputs registered; update on the clk edge where tick=1; no tick = hold.
//   - Reset (async, rst_n=0): phase=AR2, t_rem=ALL_RED, r1=r2=1, g/y=0,
//     phase_end=0, elapsed=0, rest=0. Takes effect immediately, any state.
//   - Lamps decode from phase: G1 g1&r2; Y1 y1&r2; AR1/AR2 r1&r2; G2 g2&r1; Y2 y2&r1.
//   - Phase length: t_rem loaded on entry; at each tick, if t_rem>1 decrement,
//     if t_rem==1 transition. A phase therefore lasts exactly its load value in ticks.
//   - Green load: gdur = MIN_GREEN + PER_CAR*q_own, computed >= TW+CW+2 bits wide,
//     saturated to MAX_GREEN; q_own sampled in the entry cycle.
//   - Green, priority at each tick (elapsed = ticks in this green, incl. current):
//     1. t_rem==1 or rest: q_other!=0 -> Y; else rest=1, t_rem=0, stay green.
//     2. elapsed>=MIN_GREEN and q_own==0 and q_other!=0 -> Y (gap-out).
//     3. otherwise decrement t_rem, elapsed++ (saturating at 2**TW-1).
//   - Rest-in-green persists indefinitely while q_other==0; leaves on first tick
//     with q_other!=0. Not bounded by MAX_GREEN (no conflicting demand).
//   - Y loads YELLOW; AR loads ALL_RED; no early exit; queues ignored there.
//   - Entering any phase clears elapsed and rest; phase_end=1 for that cycle only.
//   - Illegal phase code -> AR2 with t_rem=ALL_RED on next clk.
//   - Queue input changes mid-green do not alter t_rem (only gap-out/rest use them).
// TESTING
//   1. Hold rst_n=0, q1=3 -> r1=r2=1, phase=5, t_rem=1; release, 1 tick -> phase=0,
//      g1=1, t_rem=11, phase_end pulse.
//   2. q1=3,q2=5 constant -> G1 11 ticks, Y1 3, AR1 1, G2 15, Y2 3, AR2 1, repeat.
//   3. q1=20 at G1 entry -> t_rem=30 (45 saturated); q1=255 -> still 30, no wrap.
//   4. G1 entered with q1=10 (t_rem=25), q2=4; q1=0 after tick 2 -> Y1 on tick 5.
//   5. q2=0 through G1 expiry -> g1 held, t_rem=0; q2=1 -> Y1 on next tick.
//   6. Assert rst_n=0 mid-Y2, no clk edge -> r1=r2=1, phase=5 immediately.

Source files
------------

// File: rtl/phase_scheduler.sv
// Demand-driven two-road signal-phase controller.
// Sequences G1 -> Y1 -> AR1 -> G2 -> Y2 -> AR2 -> G1. Green length scales with
// the own-road queue (saturated at MAX_GREEN), ends early on gap-out, and rests
// in green indefinitely while the other road has no demand. All state and
// outputs advance only on clk edges where tick=1, except the phase_end pulse,
// which lasts exactly one clk cycle.
module phase_scheduler #(
    parameter int CW        = 8,
    parameter int TW        = 8,
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 30,
    parameter int PER_CAR   = 2,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic [CW-1:0] q1,
    input  logic [CW-1:0] q2,
    output logic          g1,
    output logic          y1,
    output logic          r1,
    output logic          g2,
    output logic          y2,
    output logic          r2,
    output logic [TW-1:0] t_rem,
    output logic [2:0]    phase,
    output logic          phase_end
);

    // Phase codes; 6 and 7 are unused and recover to AR2.
    localparam logic [2:0] PH_G1  = 3'd0;
    localparam logic [2:0] PH_Y1  = 3'd1;
    localparam logic [2:0] PH_AR1 = 3'd2;
    localparam logic [2:0] PH_G2  = 3'd3;
    localparam logic [2:0] PH_Y2  = 3'd4;
    localparam logic [2:0] PH_AR2 = 3'd5;

    // Green duration arithmetic is wide enough that MIN + PER_CAR*q never wraps.
    localparam int GW = TW + CW + 2;

    localparam logic [TW-1:0] T_ONE     = TW'(1);
    localparam logic [TW-1:0] T_YELLOW  = TW'(YELLOW);
    localparam logic [TW-1:0] T_ALL_RED = TW'(ALL_RED);
    localparam logic [TW-1:0] T_MAX     = TW'(MAX_GREEN);
    localparam logic [TW-1:0] T_EL_SAT  = {TW{1'b1}};
    // Stored elapsed excludes the tick being processed, so gap-out is allowed
    // once the stored count reaches MIN_GREEN-1 (current tick makes MIN_GREEN).
    localparam logic [TW-1:0] T_GAP     = TW'(MIN_GREEN - 1);

    // Lamp vector order: {g1, y1, r1, g2, y2, r2}.
    localparam logic [5:0] L_G1 = 6'b100_001;
    localparam logic [5:0] L_Y1 = 6'b010_001;
    localparam logic [5:0] L_AR = 6'b001_001;
    localparam logic [5:0] L_G2 = 6'b001_100;
    localparam logic [5:0] L_Y2 = 6'b001_010;

    // Green load for a given queue: MIN_GREEN + PER_CAR*q, saturated to MAX_GREEN.
    function automatic logic [TW-1:0] green_load(input logic [CW-1:0] q);
        logic [GW-1:0] full;
        full = GW'(MIN_GREEN) + GW'(PER_CAR) * GW'(q);
        if (full > GW'(MAX_GREEN)) begin
            return T_MAX;
        end
        return full[TW-1:0];
    endfunction

    // Lamp decode; illegal codes show all-red like AR2.
    function automatic logic [5:0] lamp_decode(input logic [2:0] ph);
        logic [5:0] l;
        case (ph)
            PH_G1:   l = L_G1;
            PH_Y1:   l = L_Y1;
            PH_G2:   l = L_G2;
            PH_Y2:   l = L_Y2;
            default: l = L_AR;
        endcase
        return l;
    endfunction

    // State registers.
    logic [2:0]    r_phase;
    logic [TW-1:0] r_t_rem;
    logic [TW-1:0] r_elapsed;
    logic          r_rest;
    logic          r_phase_end;
    logic [5:0]    r_lamps;

    // Combinational next-state and helpers.
    logic [TW-1:0] w_gload1;
    logic [TW-1:0] w_gload2;
    logic [2:0]    w_succ;
    logic [TW-1:0] w_succ_load;
    logic          w_in_green;
    logic          w_own_busy;
    logic          w_other_wait;
    logic [2:0]    w_phase_nxt;
    logic [TW-1:0] w_t_rem_nxt;
    logic [TW-1:0] w_elapsed_nxt;
    logic          w_rest_nxt;
    logic          w_enter;

    assign w_gload1 = green_load(q1);
    assign w_gload2 = green_load(q2);

    assign w_in_green   = (r_phase == PH_G1) || (r_phase == PH_G2);
    assign w_own_busy   = (r_phase == PH_G2) ? (q2 != '0) : (q1 != '0);
    assign w_other_wait = (r_phase == PH_G2) ? (q1 != '0) : (q2 != '0);

    // Successor of the current phase and the duration it loads on entry.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_succ      = PH_G1;
        w_succ_load = w_gload1;
        case (r_phase)
            PH_G1: begin
                w_succ      = PH_Y1;
                w_succ_load = T_YELLOW;
            end
            PH_Y1: begin
                w_succ      = PH_AR1;
                w_succ_load = T_ALL_RED;
            end
            PH_AR1: begin
                w_succ      = PH_G2;
                w_succ_load = w_gload2;
            end
            PH_G2: begin
                w_succ      = PH_Y2;
                w_succ_load = T_YELLOW;
            end
            PH_Y2: begin
                w_succ      = PH_AR2;
                w_succ_load = T_ALL_RED;
            end
            default: begin
                w_succ      = PH_G1;
                w_succ_load = w_gload1;
            end
        endcase
    end

    // Per-tick phase decision: countdown, rest-in-green, gap-out, advance.
    always_comb begin
        logic advance;
        advance       = 1'b0;
        w_phase_nxt   = r_phase;
        w_t_rem_nxt   = r_t_rem;
        w_elapsed_nxt = r_elapsed;
        w_rest_nxt    = r_rest;
        w_enter       = 1'b0;

        if (r_phase > PH_AR2) begin
            // Corrupted code: recover to all-red on the next clk, tick or not.
            w_phase_nxt   = PH_AR2;
            w_t_rem_nxt   = T_ALL_RED;
            w_elapsed_nxt = '0;
            w_rest_nxt    = 1'b0;
            w_enter       = 1'b1;
        end else if (tick) begin
            if (w_in_green) begin
                if ((r_t_rem == T_ONE) || r_rest) begin
                    // Timed out or resting: leave only if the other road waits.
                    if (w_other_wait) begin
                        advance = 1'b1;
                    end else begin
                        w_rest_nxt  = 1'b1;
                        w_t_rem_nxt = '0;
                    end
                end else if ((r_elapsed >= T_GAP) && !w_own_busy && w_other_wait) begin
                    // Gap-out: own road emptied after minimum green.
                    advance = 1'b1;
                end else begin
                    w_t_rem_nxt   = r_t_rem - T_ONE;
                    w_elapsed_nxt = (r_elapsed == T_EL_SAT) ? r_elapsed : r_elapsed + T_ONE;
                end
            end else if (r_t_rem > T_ONE) begin
                // Yellow and all-red simply run down; queues are ignored.
                w_t_rem_nxt = r_t_rem - T_ONE;
            end else begin
                advance = 1'b1;
            end

            if (advance) begin
                w_phase_nxt   = w_succ;
                w_t_rem_nxt   = w_succ_load;
                w_elapsed_nxt = '0;
                w_rest_nxt    = 1'b0;
                w_enter       = 1'b1;
            end
        end
    end

    // Register phase state and outputs; phase_end clears on the next clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase     <= PH_AR2;
            r_t_rem     <= T_ALL_RED;
            r_elapsed   <= '0;
            r_rest      <= 1'b0;
            r_phase_end <= 1'b0;
            r_lamps     <= L_AR;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_phase     <= w_phase_nxt;
            r_t_rem     <= w_t_rem_nxt;
            r_elapsed   <= w_elapsed_nxt;
            r_rest      <= w_rest_nxt;
            r_phase_end <= w_enter;
            r_lamps     <= lamp_decode(w_phase_nxt);
        end
    end

    assign {g1, y1, r1, g2, y2, r2} = r_lamps;
    assign t_rem     = r_t_rem;
    assign phase     = r_phase;
    assign phase_end = r_phase_end;

endmodule

// File: tb/tb_phase_scheduler.sv
// Scoreboard bench for phase_scheduler: the driver applies stimulus, steps a
// rule-level reference model and queues the expected post-edge outputs; a
// monitor pops and compares on every falling clock edge.
module tb_phase_scheduler;

    localparam int CW        = 8;
    localparam int TW        = 8;
    localparam int MIN_GREEN = 5;
    localparam int MAX_GREEN = 30;
    localparam int PER_CAR   = 2;
    localparam int YELLOW    = 3;
    localparam int ALL_RED   = 1;

    logic          clk;
    logic          rst_n;
    logic          tick;
    logic [CW-1:0] q1;
    logic [CW-1:0] q2;
    logic          g1, y1, r1, g2, y2, r2;
    logic [TW-1:0] t_rem;
    logic [2:0]    phase;
    logic          phase_end;

    phase_scheduler #(
        .CW(CW), .TW(TW), .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
        .PER_CAR(PER_CAR), .YELLOW(YELLOW), .ALL_RED(ALL_RED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .q1(q1), .q2(q2),
        .g1(g1), .y1(y1), .r1(r1), .g2(g2), .y2(y2), .r2(r2),
        .t_rem(t_rem), .phase(phase), .phase_end(phase_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (rule level) ----------------
    // Phase index 0..5 = G1 Y1 AR1 G2 Y2 AR2; lamps {g1,y1,r1,g2,y2,r2}.
    bit [5:0] lamp_tab [6] = '{6'b100001, 6'b010001, 6'b001001,
                               6'b001100, 6'b001010, 6'b001001};

    int m_ph, m_trem, m_green_ticks;
    bit m_rest, m_pe;

    typedef struct {
        int       ph;
        int       trem;
        bit       pe;
        bit [5:0] lamps;
    } exp_t;
    exp_t sb[$];

    function automatic int green_len(input int q);
        int d;
        d = MIN_GREEN + PER_CAR * q;
        return (d > MAX_GREEN) ? MAX_GREEN : d;
    endfunction

    task automatic model_reset();
        m_ph = 5; m_trem = ALL_RED; m_green_ticks = 0; m_rest = 0; m_pe = 0;
    endtask

    task automatic model_enter_next(input int a, input int b);
        m_ph = (m_ph + 1) % 6;
        if (m_ph == 0)                      m_trem = green_len(a);
        else if (m_ph == 3)                 m_trem = green_len(b);
        else if (m_ph == 1 || m_ph == 4)    m_trem = YELLOW;
        else                                m_trem = ALL_RED;
        m_green_ticks = 0;
        m_rest = 0;
        m_pe = 1;
    endtask

    task automatic model_step(input bit t, input int a, input int b);
        int own, other, now_ticks;
        m_pe = 0;
        if (!t) return;
        if (m_ph == 0 || m_ph == 3) begin
            own       = (m_ph == 0) ? a : b;
            other     = (m_ph == 0) ? b : a;
            now_ticks = m_green_ticks + 1;   // ticks in this green incl. this one
            if (m_trem == 1 || m_rest) begin
                if (other != 0) model_enter_next(a, b);
                else begin m_rest = 1; m_trem = 0; end
            end else if (now_ticks >= MIN_GREEN && own == 0 && other != 0) begin
                model_enter_next(a, b);
            end else begin
                m_trem--;
                m_green_ticks = (now_ticks > 255) ? 255 : now_ticks;
            end
        end else if (m_trem == 1) begin
            model_enter_next(a, b);
        end else begin
            m_trem--;
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge; returns just after the next one.
    task automatic drive(input bit t, input int a, input int b);
        exp_t e;
        tick = t;
        q1   = a[CW-1:0];
        q2   = b[CW-1:0];
        @(posedge clk);
        model_step(t, a, b);
        e.ph = m_ph; e.trem = m_trem; e.pe = m_pe; e.lamps = lamp_tab[m_ph];
        sb.push_back(e);
        @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("phase", int'(phase), e.ph);
                check("t_rem", int'(t_rem), e.trem);
                check("phase_end", int'(phase_end), int'(e.pe));
                check("lamps", int'({g1, y1, r1, g2, y2, r2}), int'(e.lamps));
            end
        end
    end

    // ---------------- stimulus ----------------
    int pool [9] = '{0, 0, 1, 2, 3, 10, 20, 255, 0};

    initial begin
        int ra, rb, guard;
        rst_n = 1'b0; tick = 1'b0; q1 = 8'd3; q2 = 8'd0;
        model_reset();

        // Reset state while held, with a queue present.
        repeat (3) @(negedge clk);
        check("rst_phase", int'(phase), 5);
        check("rst_t_rem", int'(t_rem), ALL_RED);
        check("rst_r1r2", int'({r1, r2}), 3);
        check("rst_gy", int'({g1, y1, g2, y2}), 0);
        check("rst_phase_end", int'(phase_end), 0);
        rst_n = 1'b1;

        // First tick enters G1 with 5+2*3=11.
        drive(1, 3, 0);
        drive(0, 3, 0);

        // Constant demand on both roads: full timed cycles.
        for (int i = 0; i < 140; i++) drive(i % 3 != 2, 3, 5);

        // Green saturation: 45 clamps to 30, 515 also clamps to 30.
        for (int i = 0; i < 80; i++) drive(1, 20, 1);
        for (int i = 0; i < 80; i++) drive(1, 255, 1);

        // Gap-out: enter G1 with q1=10, empty road 1 after two ticks.
        guard = 0;
        while (!(m_ph == 5 && m_trem == 1) && guard < 200) begin
            drive(1, 10, 4);
            guard++;
        end
        check("gap_setup_reached", int'(guard < 200), 1);
        drive(1, 10, 4);
        drive(1, 10, 4);
        drive(1, 10, 4);
        for (int i = 0; i < 8; i++) drive(1, 0, 4);

        // Rest in green with no competing demand, then release.
        for (int i = 0; i < 60; i++) drive(1, 3, 0);
        for (int i = 0; i < 10; i++) drive(1, 3, 1);
        for (int i = 0; i < 60; i++) drive(1, 0, 3);
        for (int i = 0; i < 10; i++) drive(1, 2, 3);

        // Randomized traffic with sporadic ticks and queue changes.
        ra = 3; rb = 2;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0)
                ra = ($urandom_range(0, 9) == 9) ? int'($urandom_range(0, 255)) : pool[$urandom_range(0, 8)];
            if ($urandom_range(0, 7) == 0)
                rb = ($urandom_range(0, 9) == 9) ? int'($urandom_range(0, 255)) : pool[$urandom_range(0, 8)];
            drive($urandom_range(0, 3) != 0, ra, rb);
        end

        // Asynchronous reset in the middle of Y2, checked before any clk edge.
        guard = 0;
        while (!(m_ph == 4 && m_trem == 2) && guard < 200) begin
            drive(1, 3, 5);
            guard++;
        end
        check("y2_setup_reached", int'(guard < 200), 1);
        tick = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_phase", int'(phase), 5);
        check("async_rst_r1r2", int'({r1, r2}), 3);
        check("async_rst_t_rem", int'(t_rem), ALL_RED);
        check("async_rst_gy", int'({g1, y1, g2, y2}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 40; i++) drive(1, 4, 2);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
